matrix_ls_sequencer: RTL
========================

Name: matrix_ls_sequencer

Overview:
- Sits directly downstream of the matrix load/store functional unit.
- Accepts one decoded matrix load/store command: op, destination matrix register, resolved base address, 11-bit immediate and stride.
- Turns that command into a sequence of per-row scratchpad requests, handshaking each row on mhit.
- Reports completion of the whole matrix transfer to writeback and the scoreboard.

Parameters:
- ROWS, 4, number of matrix rows transferred per command (power of two, ≥2).
- ADDR_W, 32, address and stride width.
- TIMEOUT_CYCLES, 255, maximum wait cycles per row; used only with the optional feature.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_ls  in  2  01 = load, 10 = store, 00/11 = no-op
- cmd_rd  in  4  matrix register index
- cmd_base  in  ADDR_W  base address (rs value)
- cmd_imm  in  11  signed offset
- cmd_stride  in  ADDR_W  byte distance between rows
- sp_req  out  1  scratchpad row request valid
- sp_write  out  1  1 = store row, 0 = load row
- sp_addr  out  ADDR_W  row address
- sp_row  out  $clog2(ROWS)  row index within matrix
- sp_mreg  out  4  matrix register index for this row
- mhit  in  1  scratchpad accepted/completed current row
- done  out  1  one-cycle pulse, transfer complete
- done_rd  out  4  register index associated with done
- done_ls  out  2  op associated with done
- busy  out  1  sequencer not IDLE
- err  out  1  one-cycle pulse on timeout (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, nRST low): state = IDLE; all registered outputs 0; cmd_ready = 1 once nRST is released.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid with cmd_ls of 01 or 10:
    - latch ls, rd and stride;
    - addr = cmd_base + sign_extend(cmd_imm), modulo 2^ADDR_W;
    - row = 0; go to ISSUE.
  - On cmd_valid with cmd_ls of 00 or 11: consume the command; no requests, no done; stay IDLE.
- ISSUE:
  - sp_req = 1, sp_write = (ls == 10), sp_addr = addr, sp_row = row, sp_mreg = rd; cmd_ready = 0.
  - sp_req and its payload are held stable until the cycle mhit = 1 is sampled.
  - On mhit with row < ROWS-1: row += 1; addr += stride (wraps modulo 2^ADDR_W). The next row is presented in the following cycle, so there is no bubble beyond the handshake cycle.
  - On mhit with row == ROWS-1: go to DONE.
  - mhit while in IDLE or DONE is ignored.
- DONE:
  - done = 1 for exactly one cycle; done_rd and done_ls are valid in that cycle.
  - sp_req = 0; cmd_ready = 0; next state IDLE.
- Latency: command accept → first sp_req is 1 cycle. With mhit tied high, done rises ROWS+1 cycles after the accept edge.
- Back-to-back: a new command is accepted in the IDLE cycle that follows DONE. Minimum spacing is ROWS+2 cycles.
- busy = 1 in ISSUE and DONE.
- Stride 0 is legal: the same address repeats ROWS times.
- Reset asserted mid-transfer aborts immediately; no done is produced and no partial state is kept.

Optional Feature:
- Macro: MATRIX_LS_SEQ_TIMEOUT_EN.
- When defined:
  - an 8-bit-or-wider wait counter clears on every row entry and on every mhit, and increments each ISSUE cycle without mhit;
  - when the counter reaches TIMEOUT_CYCLES, drop sp_req, pulse err for one cycle with done_rd = rd, and return to IDLE without a done pulse.
- When undefined: no counter exists, err is constant 0, and ISSUE waits indefinitely for mhit.

Test Plan:
- Load, mhit tied 1: base=0x1000, imm=0x010, stride=0x20 → sp_addr 0x1010, 0x1030, 0x1050, 0x1070; sp_write=0; done pulses with done_rd=cmd_rd 5 cycles after accept.
- Store with mhit delayed 3 cycles per row: sp_req and payload stay stable during the delay; sp_write=1; done arrives 17 cycles after accept.
- Negative imm and wrap: base=0x00000004, imm=0x7F8 (−8), stride=0x10 → first sp_addr 0xFFFFFFFC, second 0x0000000C.
- cmd_ls=11 with cmd_valid for 1 cycle → no sp_req, no done, cmd_ready stays 1.
- nRST pulsed low during row 2 of a load → all outputs 0 at once, no done, cmd_ready=1 after release, next command restarts at row 0.
- MATRIX_LS_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, mhit held 0 → err pulses after 8 ISSUE cycles, busy clears, no done.

Source files
------------

// File: rtl/matrix_ls_sequencer.sv
// Turns one decoded matrix load/store command into ROWS scratchpad row requests, each handshaked on mhit.
// Optional per-row wait timeout is enabled by defining MATRIX_LS_SEQ_TIMEOUT_EN.
module matrix_ls_sequencer #(
   parameter int ROWS           = 4,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_ls,
   input  logic [3:0]              cmd_rd,
   input  logic [ADDR_W-1:0]       cmd_base,
   input  logic [10:0]             cmd_imm,
   input  logic [ADDR_W-1:0]       cmd_stride,
   output logic                    sp_req,
   output logic                    sp_write,
   output logic [ADDR_W-1:0]       sp_addr,
   output logic [$clog2(ROWS)-1:0] sp_row,
   output logic [3:0]              sp_mreg,
   input  logic                    mhit,
   output logic                    done,
   output logic [3:0]              done_rd,
   output logic [1:0]              done_ls,
   output logic                    busy,
   output logic                    err
);

   localparam int ROW_W = $clog2(ROWS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [1:0]          ls_q;
   logic [3:0]          rd_q;
   logic [ADDR_W-1:0]   stride_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ROW_W-1:0]    row_q;

   logic                issue;
   logic                accept;
   logic                last_row;
   logic                advance;
   logic                timeout;
   logic [ADDR_W-1:0]   imm_ext;

   assign issue    = (state == ISSUE);
   assign accept   = (state == IDLE) && cmd_valid && ((cmd_ls == 2'b01) || (cmd_ls == 2'b10));
   assign last_row = (row_q == ROW_W'(ROWS - 1));
   assign advance  = issue && mhit && !last_row;
   assign imm_ext  = {{(ADDR_W-11){cmd_imm[10]}}, cmd_imm};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values;
   // the command payload registers are reset too, because they drive done_rd/done_ls directly.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         ls_q     <= '0;
         rd_q     <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         row_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ls_q     <= cmd_ls;
            rd_q     <= cmd_rd;
            stride_q <= cmd_stride;
            addr_q   <= cmd_base + imm_ext;
            row_q    <= '0;
         end else if (advance) begin
            row_q  <= row_q + 1'b1;
            addr_q <= addr_q + stride_q;
         end
      end
   end

   // NOTE: next state defaults to the current state first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE: begin
            if (mhit && last_row) state_nxt = DONE;
            else if (timeout)     state_nxt = IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MATRIX_LS_SEQ_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WAIT_W-1:0] wait_q;
   logic              err_q;

   // Timeout fires on the edge where the count would reach TIMEOUT_CYCLES, so sp_req drops right then.
   assign timeout = issue && !mhit && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= timeout;
         if (issue && !mhit && !timeout) wait_q <= wait_q + 1'b1;
         else                            wait_q <= '0;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // cmd_ready is gated by nRST so the interface reads as fully quiet while reset is held.
   assign cmd_ready = nRST && (state == IDLE);
   assign sp_req    = issue;
   assign sp_write  = issue && (ls_q == 2'b10);
   assign sp_addr   = issue ? addr_q : '0;
   assign sp_row    = issue ? row_q  : '0;
   assign sp_mreg   = issue ? rd_q   : '0;
   assign done      = (state == DONE);
   assign done_rd   = rd_q;
   assign done_ls   = ls_q;
   assign busy      = (state != IDLE);

endmodule
